// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with
// double-buffered BCD frame, anti-ghost blanking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 16,
  parameter int BLANK  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  lzs,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [6:0]            seg,
  output logic                  err,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
  localparam logic [IW-1:0] DIG_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]          div_cnt;
  logic [IW-1:0]          dig_idx;
  logic [4*DIGITS-1:0]    shadow;
  logic [4*DIGITS-1:0]    disp;
  logic                   pending;
  logic                   fb;

  logic [3:0]             cur;
  logic [DIGITS-1:0]      zero_from;
  logic                   suppress;
  logic [DIGITS-1:0]      one_hot;
  logic [DIGITS-1:0]      dig_sel_d;
  logic [6:0]             seg_d;
  logic                   err_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign fb = enable && (div_cnt == DIV_LAST) && (dig_idx == DIG_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + IW'(1);
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // disp only moves on a frame boundary so a frame is never torn
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (load) begin
      shadow <= data_in;
      if (fb) begin
        disp    <= data_in;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (fb && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  end

  // zero_from[i]: digit i and every digit above it are zero
  always_comb begin
    zero_from = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_from[i] = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        if (disp[4*j +: 4] != 4'd0) zero_from[i] = 1'b0;
      end
    end
  end

  assign cur      = disp[{dig_idx, 2'b00} +: 4];
  assign suppress = lzs && (dig_idx != '0) && zero_from[dig_idx];
  assign one_hot  = DIGITS'(1) << dig_idx;

  always_comb begin
    dig_sel_d = '0;
    seg_d     = '0;
    err_d     = 1'b0;
    if (enable && (div_cnt >= BLANK_C)) begin
      if (cur > 4'd9) begin
        dig_sel_d = one_hot;
        err_d     = 1'b1;
      end else if (!suppress) begin
        dig_sel_d = one_hot;
        seg_d     = decode(cur);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_sel    <= '0;
      seg        <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dig_sel    <= dig_sel_d;
      seg        <= seg_d;
      err        <= err_d;
      frame_done <= fb;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a
// position-arithmetic display model.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        lzs;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dig_sel;
  logic [6:0]  seg;
  logic        err;
  logic        frame_done;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .lzs(lzs), .load(load),
    .data_in(data_in), .dig_sel(dig_sel), .seg(seg), .err(err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dsel;
    logic [6:0] seg;
    logic       err;
    logic       fd;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011};

  // model state: pos counts enabled cycles since the scan (re)started
  int          pos;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend, m_fb;
  int          m_slot, m_ph, m_d;
  exp_t        m_e;

  function automatic int digit_of(logic [15:0] v, int i);
    return int'((v >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit is_suppressed(logic [15:0] v, int i, bit lz);
    if (!lz || i == 0) return 1'b0;
    for (int j = i; j < DIGITS; j++) if (digit_of(v, j) != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_e = '0;
    if (!reset) begin
      pos = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    end else begin
      m_fb = 1'b0;
      if (enable) begin
        m_slot = (pos / DIV) % DIGITS;
        m_ph   = pos % DIV;
        m_d    = digit_of(m_disp, m_slot);
        m_fb   = (pos % FRAME) == FRAME - 1;
        if (m_ph >= BLANK) begin
          if (m_d > 9) begin
            m_e.dsel = 4'(1 << m_slot);
            m_e.err  = 1'b1;
          end else if (!is_suppressed(m_disp, m_slot, lzs)) begin
            m_e.dsel = 4'(1 << m_slot);
            m_e.seg  = segtab[m_d];
          end
        end
        m_e.fd = m_fb;
        pos++;
      end else begin
        pos = 0;
      end
      if (load) begin
        m_shadow = data_in;
        if (m_fb) begin m_disp = data_in; m_pend = 1'b0; end
        else m_pend = 1'b1;
      end else if (m_fb && m_pend) begin
        m_disp = m_shadow; m_pend = 1'b0;
      end
    end
    expq.push_back(m_e);
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      if (!reset) mon_e = '0;
      checks++;
      if ({dig_sel, seg, err, frame_done} !== mon_e) begin
        errors++;
        $display("FAIL out t=%0t got sel=%b seg=%b err=%b fd=%b want sel=%b seg=%b err=%b fd=%b",
                 $time, dig_sel, seg, err, frame_done, mon_e.dsel, mon_e.seg, mon_e.err, mon_e.fd);
      end
      checks++;
      if ($countones(dig_sel) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t got sel=%b want at most one bit", $time, dig_sel);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; data_in = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic check_dark(input string name);
    checks++;
    if ({dig_sel, seg, err, frame_done} !== 12'd0) begin
      errors++;
      $display("FAIL %s got sel=%b seg=%b err=%b fd=%b want all zero",
               name, dig_sel, seg, err, frame_done);
    end
  endtask

  // advance until the next posedge will act on scan position target
  task automatic wait_pos(input int slot, input int ph, input string name);
    int n;
    n = 0;
    while (!(((pos / DIV) % DIGITS) == slot && (pos % DIV) == ph) && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout got pos=%0d want slot %0d phase %0d", name, pos, slot, ph);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; lzs = 1'b0; load = 1'b1; data_in = 16'h1234;
    step(3);
    check_dark("reset_dark");
    load = 1'b0; reset = 1'b1;
    step(40);
    do_load(16'h1234);
    step(80);
    lzs = 1'b1;
    do_load(16'h0050); step(70);
    do_load(16'h0000); step(70);
    lzs = 1'b0;
    do_load(16'h00A0); step(70);
    wait_pos(DIGITS - 1, DIV - 1, "wait_fb");
    load = 1'b1; data_in = 16'h9999;
    step(1);
    data_in = 16'h5678;
    step(1);
    load = 1'b0;
    step(80);
    wait_pos(2, 4, "wait_en_drop");
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(40);
    wait_pos(2, 5, "wait_reset");
    reset = 1'b0;
    #1;
    check_dark("async_reset");
    step(2);
    reset = 1'b1;
    do_load(16'h4321);
    step(70);
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 49) == 0) lzs = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) begin
        load = 1'b1;
        for (int k = 0; k < DIGITS; k++)
          data_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      end else begin
        load = 1'b0;
      end
      step(1);
    end
    load = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
